// File: rtl/switch_input_pio.sv
// Debounced switch input port with edge capture and a level interrupt, exposed
// as a four-register Avalon-MM slave (DATA, IRQ_MASK, RAW, EDGE_CAP).

module switch_input_pio_bit #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int EDGE_TYPE       = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in_i,
   output logic raw_o,
   output logic stable_o,
   output logic event_o
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   stable_q, stable_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= '0;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
   end

   assign raw_o = sync_q[SYNC_STAGES-1];

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign stable_d = raw_o;
      end else begin : g_debounce
         localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);
         logic [15:0] cnt_q, cnt_d;

         // Any return to the stable level restarts the window from zero.
         always_comb begin
            cnt_d    = cnt_q + 16'd1;
            stable_d = stable_q;
            if (raw_o == stable_q) begin
               cnt_d = '0;
            end else if (cnt_q == LAST) begin
               stable_d = raw_o;
               cnt_d    = '0;
            end
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) cnt_q <= '0;
            else          cnt_q <= cnt_d;
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) stable_q <= 1'b0;
      else          stable_q <= stable_d;
   end

   assign stable_o = stable_q;

   // Event is raised in the cycle before stable_q flips so capture lands on the same edge.
   always_comb begin
      if (EDGE_TYPE == 0)      event_o = stable_d & ~stable_q;
      else if (EDGE_TYPE == 1) event_o = ~stable_d & stable_q;
      else                     event_o = stable_d ^ stable_q;
   end
endmodule

module switch_input_pio #(
   parameter int WIDTH           = 10,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int EDGE_TYPE       = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);
   logic [WIDTH-1:0] raw, stable, evt;
   logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
   logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
   logic [31:0]      readdata_q, readdata_d;
   logic             wr;
   logic             unused_wdata;

   switch_input_pio_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_TYPE      (EDGE_TYPE)
   ) u_bit [WIDTH-1:0] (
      .clk     (clk),
      .reset_n (reset_n),
      .in_i    (in_port),
      .raw_o   (raw),
      .stable_o(stable),
      .event_o (evt)
   );

   assign wr           = chipselect & ~write_n;
   assign unused_wdata = ^writedata;

   always_comb begin
      irq_mask_d = irq_mask_q;
      if (wr && address == 2'd1) irq_mask_d = writedata[WIDTH-1:0];

      // Clear first, then OR in new events so a coincident set wins.
      edge_cap_d = edge_cap_q;
      if (wr && address == 2'd3) edge_cap_d = edge_cap_q & ~writedata[WIDTH-1:0];
      edge_cap_d = edge_cap_d | evt;

      readdata_d = '0;
      case (address)
         2'd0:    readdata_d[WIDTH-1:0] = stable;
         2'd1:    readdata_d[WIDTH-1:0] = irq_mask_q;
         2'd2:    readdata_d[WIDTH-1:0] = raw;
         default: readdata_d[WIDTH-1:0] = edge_cap_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask_q <= '0;
         edge_cap_q <= '0;
         readdata_q <= '0;
      end else begin
         irq_mask_q <= irq_mask_d;
         edge_cap_q <= edge_cap_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = |(edge_cap_q & irq_mask_q);
endmodule

// File: tb/tb_switch_input_pio.sv
// Bench for switch_input_pio: main instance (debounce 4, any edge), a rising-edge
// instance and a debounce-bypass instance sharing the bus signals.

module tb_switch_input_pio;
   logic        clk, reset_n;
   logic [1:0]  address;
   logic        chipselect, write_n;
   logic [31:0] writedata;
   logic [9:0]  in_port, in_r, in_b;
   logic [31:0] readdata, readdata_r, readdata_b;
   logic        irq, irq_r, irq_b;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] e;

   switch_input_pio #(.WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata), .irq(irq));

   switch_input_pio #(.WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut_r (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_r),
      .readdata(readdata_r), .irq(irq_r));

   switch_input_pio #(.WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) dut_b (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_b),
      .readdata(readdata_b), .irq(irq_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic steps(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      steps(1);
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
      writedata = '0; in_port = '0; in_r = '0; in_b = '0;
      steps(3);
      checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL reset_rd got=%h exp=%h", readdata, 32'h0); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
      reset_n = 1'b1;
      address = 2'd1; exp_q.push_back(32'h0);
      steps(1);
      e = exp_q.pop_front();
      checks++; if (readdata !== e) begin failures++; $display("FAIL reset_mask got=%h exp=%h", readdata, e); end
   endtask

   task automatic test_debounce;
      in_port = 10'h001; address = 2'd0;
      exp_q.push_back(32'h0); exp_q.push_back(32'h1);
      steps(6);
      e = exp_q.pop_front();
      checks++; if (readdata !== e) begin failures++; $display("FAIL v1_data_k5 got=%h exp=%h", readdata, e); end
      steps(1);
      e = exp_q.pop_front();
      checks++; if (readdata !== e) begin failures++; $display("FAIL v1_data_k6 got=%h exp=%h", readdata, e); end
      address = 2'd3; exp_q.push_back(32'h1);
      steps(1);
      e = exp_q.pop_front();
      checks++; if (readdata !== e) begin failures++; $display("FAIL v1_edge_cap got=%h exp=%h", readdata, e); end
      address = 2'd2; exp_q.push_back(32'h1);
      steps(1);
      e = exp_q.pop_front();
      checks++; if (readdata !== e) begin failures++; $display("FAIL v1_raw got=%h exp=%h", readdata, e); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL v1_irq_unmasked got=%b exp=0", irq); end
      bus_write(2'd3, 32'h3FF);
   endtask

   task automatic test_glitch;
      address = 2'd2; in_port = 10'h009; exp_q.push_back(32'h9);
      steps(3);
      e = exp_q.pop_front();
      checks++; if (readdata !== e) begin failures++; $display("FAIL v2_raw_glitch got=%h exp=%h", readdata, e); end
      in_port = 10'h001;
      steps(8);
      address = 2'd0; exp_q.push_back(32'h1);
      steps(1);
      e = exp_q.pop_front();
      checks++; if (readdata !== e) begin failures++; $display("FAIL v2_data got=%h exp=%h", readdata, e); end
      address = 2'd3; exp_q.push_back(32'h0);
      steps(1);
      e = exp_q.pop_front();
      checks++; if (readdata !== e) begin failures++; $display("FAIL v2_edge_cap got=%h exp=%h", readdata, e); end
   endtask

   task automatic test_irq;
      bus_write(2'd1, 32'h1);
      in_port = 10'h000;
      steps(7);
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL v3_irq_set got=%b exp=1", irq); end
      bus_write(2'd3, 32'h1);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL v3_irq_clear got=%b exp=0", irq); end
      address = 2'd3; exp_q.push_back(32'h0);
      steps(1);
      e = exp_q.pop_front();
      checks++; if (readdata !== e) begin failures++; $display("FAIL v3_cap_clear got=%h exp=%h", readdata, e); end
      bus_write(2'd1, 32'h0);
      in_port = 10'h001;
      steps(7);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL v3_irq_masked got=%b exp=0", irq); end
      address = 2'd3; exp_q.push_back(32'h1);
      steps(1);
      e = exp_q.pop_front();
      checks++; if (readdata !== e) begin failures++; $display("FAIL v3_cap_masked got=%h exp=%h", readdata, e); end
      bus_write(2'd3, 32'h1);
   endtask

   task automatic test_set_wins;
      in_port = 10'h000; address = 2'd3;
      exp_q.push_back(32'h0); exp_q.push_back(32'h1);
      steps(5);
      chipselect = 1'b1; write_n = 1'b0; writedata = 32'h1;
      steps(1);
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      e = exp_q.pop_front();
      checks++; if (readdata !== e) begin failures++; $display("FAIL v4_cap_before got=%h exp=%h", readdata, e); end
      steps(1);
      e = exp_q.pop_front();
      checks++; if (readdata !== e) begin failures++; $display("FAIL v4_set_wins got=%h exp=%h", readdata, e); end
      bus_write(2'd3, 32'h3FF);
   endtask

   task automatic test_back_to_back;
      address = 2'd1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h2AA);
      chipselect = 1'b1; write_n = 1'b0; writedata = 32'hFFFF_F2AA;
      steps(1);
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      e = exp_q.pop_front();
      checks++; if (readdata !== e) begin failures++; $display("FAIL rw_pre_write got=%h exp=%h", readdata, e); end
      steps(1);
      e = exp_q.pop_front();
      checks++; if (readdata !== e) begin failures++; $display("FAIL rw_mask_width got=%h exp=%h", readdata, e); end
      bus_write(2'd0, 32'h3FF);
      address = 2'd0; exp_q.push_back(32'h0);
      steps(1);
      e = exp_q.pop_front();
      checks++; if (readdata !== e) begin failures++; $display("FAIL ro_data_write got=%h exp=%h", readdata, e); end
      bus_write(2'd1, 32'h0);
   endtask

   task automatic test_edge_rise;
      in_r = 10'h001;
      steps(7);
      address = 2'd3; exp_q.push_back(32'h1);
      steps(1);
      e = exp_q.pop_front();
      checks++; if (readdata_r !== e) begin failures++; $display("FAIL v5_rise_cap got=%h exp=%h", readdata_r, e); end
      bus_write(2'd3, 32'h1);
      in_r = 10'h000;
      steps(7);
      address = 2'd3; exp_q.push_back(32'h0);
      steps(1);
      e = exp_q.pop_front();
      checks++; if (readdata_r !== e) begin failures++; $display("FAIL v5_no_fall_cap got=%h exp=%h", readdata_r, e); end
      address = 2'd0; exp_q.push_back(32'h0);
      steps(1);
      e = exp_q.pop_front();
      checks++; if (readdata_r !== e) begin failures++; $display("FAIL v5_rise_data got=%h exp=%h", readdata_r, e); end
   endtask

   task automatic test_bypass;
      address = 2'd0; in_b = 10'h155;
      exp_q.push_back(32'h0); exp_q.push_back(32'h155);
      steps(3);
      e = exp_q.pop_front();
      checks++; if (readdata_b !== e) begin failures++; $display("FAIL v5_bypass_early got=%h exp=%h", readdata_b, e); end
      steps(1);
      e = exp_q.pop_front();
      checks++; if (readdata_b !== e) begin failures++; $display("FAIL v5_bypass_data got=%h exp=%h", readdata_b, e); end
      address = 2'd3; exp_q.push_back(32'h155);
      steps(1);
      e = exp_q.pop_front();
      checks++; if (readdata_b !== e) begin failures++; $display("FAIL v5_bypass_cap got=%h exp=%h", readdata_b, e); end
   endtask

   task automatic test_reset_mid;
      bus_write(2'd1, 32'h3FF);
      in_port = 10'h001;
      steps(7);
      address = 2'd0; exp_q.push_back(32'h1);
      steps(1);
      e = exp_q.pop_front();
      checks++; if (readdata !== e) begin failures++; $display("FAIL v6_pre_data got=%h exp=%h", readdata, e); end
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL v6_pre_irq got=%b exp=1", irq); end
      in_port = 10'h3FF;
      steps(3);
      reset_n = 1'b0;
      #1;
      checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL v6_async_rd got=%h exp=%h", readdata, 32'h0); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL v6_async_irq got=%b exp=0", irq); end
      steps(2);
      reset_n = 1'b1; address = 2'd0;
      exp_q.push_back(32'h0); exp_q.push_back(32'h3FF);
      steps(6);
      e = exp_q.pop_front();
      checks++; if (readdata !== e) begin failures++; $display("FAIL v6_data_edge6 got=%h exp=%h", readdata, e); end
      steps(1);
      e = exp_q.pop_front();
      checks++; if (readdata !== e) begin failures++; $display("FAIL v6_data_edge7 got=%h exp=%h", readdata, e); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL v6_irq_mask_cleared got=%b exp=0", irq); end
      address = 2'd3; exp_q.push_back(32'h3FF);
      steps(1);
      e = exp_q.pop_front();
      checks++; if (readdata !== e) begin failures++; $display("FAIL v6_cap got=%h exp=%h", readdata, e); end
      address = 2'd1; exp_q.push_back(32'h0);
      steps(1);
      e = exp_q.pop_front();
      checks++; if (readdata !== e) begin failures++; $display("FAIL v6_mask_reset got=%h exp=%h", readdata, e); end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_glitch();
      test_irq();
      test_set_wins();
      test_back_to_back();
      test_edge_rise();
      test_bypass();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
